// File: rtl/vip_ctrl.sv
// Frame-synchronous configuration controller for the VIP YUV->RGB pipeline: shadow/active config,
// frame counter and input geometry check. Define VIP_CTRL_IRQ_EN to build the frame-end interrupt.
module vip_ctrl #(
    parameter int unsigned WIDTH    = 1280,
    parameter int unsigned HEIGHT   = 960,
    parameter logic [7:0]  CTRL_RST = 8'h0C
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        in_href,
    input  logic        in_vsync,
    input  logic [2:0]  av_address,
    input  logic        av_write,
    input  logic [31:0] av_writedata,
    input  logic        av_read,
    output logic [31:0] av_readdata,
    output logic        hist_equ_en,
    output logic        sobel_en,
    output logic        yuv2rgb_en,
    output logic        dscale_en,
    output logic [3:0]  dscale_scale,
    output logic        irq
);
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;
    localparam int unsigned GW = 8;

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_FCNT   = 3'd2;
    localparam logic [2:0] A_GEOM   = 3'd3;
    localparam logic [2:0] A_ACTIVE = 3'd4;
    localparam logic [2:0] A_IRQEN  = 3'd5;

    typedef enum logic [1:0] {S_WAIT = 2'd0, S_BLANK = 2'd1, S_ACTIVE = 2'd2} state_t;

    state_t         state_q, state_d;
    logic           href_q, vsync_q, href_p_q, vsync_p_q;
    logic [GW-1:0]  shadow_q, shadow_d, active_q, active_d;
    logic           pending_q, pending_d;
    logic [DW-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CW-1:0]  line_cnt_q, line_cnt_d, pix_cnt_q, pix_cnt_d;
    logic [CW-1:0]  last_lines_q, last_lines_d, last_pix_q, last_pix_d;
    logic           size_err_q, size_err_d;
    logic [DW-1:0]  rdata_q, rdata_d;

    logic href_rise_c, href_fall_c, vsync_rise_c, vsync_fall_c;
    logic frame_end_c, frame_start_c, in_frame_c;
    logic wr_ctrl_c, wr_status_c, wr_fcnt_c, wr_irqen_c;
    logic err_set_c, irq_flag_c, irq_en_c;
    logic unused_c;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    // Input synchroniser plus one delayed copy for edge detection
    always_ff @(posedge pclk) begin
        if (rst) begin
            href_q    <= 1'b0;
            vsync_q   <= 1'b0;
            href_p_q  <= 1'b0;
            vsync_p_q <= 1'b0;
        end else begin
            href_q    <= in_href;
            vsync_q   <= in_vsync;
            href_p_q  <= href_q;
            vsync_p_q <= vsync_q;
        end
    end

    assign href_rise_c  =  href_q  & ~href_p_q;
    assign href_fall_c  = ~href_q  &  href_p_q;
    assign vsync_rise_c =  vsync_q & ~vsync_p_q;
    assign vsync_fall_c = ~vsync_q &  vsync_p_q;

    assign wr_ctrl_c   = av_write && (av_address == A_CTRL);
    assign wr_status_c = av_write && (av_address == A_STATUS);
    assign wr_fcnt_c   = av_write && (av_address == A_FCNT);
    assign wr_irqen_c  = av_write && (av_address == A_IRQEN);

    always_ff @(posedge pclk) begin
        if (rst) state_q <= S_WAIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT:   if (vsync_rise_c) state_d = S_BLANK;
            S_BLANK:  if (vsync_fall_c) state_d = S_ACTIVE;
            S_ACTIVE: if (vsync_rise_c) state_d = S_BLANK;
            default:  state_d = S_WAIT;
        endcase
    end

    always_comb begin
        frame_end_c   = 1'b0;
        frame_start_c = 1'b0;
        in_frame_c    = 1'b0;
        case (state_q)
            S_BLANK:  frame_start_c = vsync_fall_c;
            S_ACTIVE: begin
                in_frame_c  = 1'b1;
                frame_end_c = vsync_rise_c;
            end
            default: ;
        endcase
    end

    // A short/long line is caught at its href fall; a wrong line count at frame end
    assign err_set_c = (in_frame_c && href_fall_c && (pix_cnt_q != CW'(WIDTH))) ||
                       (frame_end_c && (line_cnt_q != CW'(HEIGHT)));

    always_comb begin
        shadow_d     = shadow_q;
        active_d     = active_q;
        pending_d    = pending_q;
        frame_cnt_d  = frame_cnt_q;
        line_cnt_d   = line_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        last_lines_d = last_lines_q;
        last_pix_d   = last_pix_q;
        rdata_d      = rdata_q;
        size_err_d   = (size_err_q & ~(wr_status_c & av_writedata[2])) | err_set_c;

        if (frame_start_c) begin
            line_cnt_d = '0;
            pix_cnt_d  = '0;
        end else if (in_frame_c) begin
            if (href_rise_c) begin
                line_cnt_d = sat_inc(line_cnt_q);
                pix_cnt_d  = CW'(1);
            end else if (href_q) begin
                pix_cnt_d = sat_inc(pix_cnt_q);
            end
        end

        if (frame_end_c) begin
            last_lines_d = line_cnt_q;
            last_pix_d   = pix_cnt_q;
            frame_cnt_d  = frame_cnt_q + DW'(1);
            if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end

        // A write landing on the apply cycle is held for the next frame
        if (wr_ctrl_c) begin
            shadow_d = av_writedata[GW-1:0];
            if (state_q == S_WAIT) active_d  = av_writedata[GW-1:0];
            else                   pending_d = 1'b1;
        end

        if (wr_fcnt_c) frame_cnt_d = '0;

        if (av_read) begin
            case (av_address)
                A_CTRL:   rdata_d = DW'(shadow_q);
                A_STATUS: rdata_d = DW'({irq_flag_c, size_err_q, in_frame_c, pending_q});
                A_FCNT:   rdata_d = frame_cnt_q;
                A_GEOM:   rdata_d = {last_lines_q, last_pix_q};
                A_ACTIVE: rdata_d = DW'(active_q);
                A_IRQEN:  rdata_d = DW'(irq_en_c);
                default:  rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            shadow_q     <= CTRL_RST;
            active_q     <= CTRL_RST;
            pending_q    <= 1'b0;
            frame_cnt_q  <= '0;
            line_cnt_q   <= '0;
            pix_cnt_q    <= '0;
            last_lines_q <= '0;
            last_pix_q   <= '0;
            size_err_q   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            frame_cnt_q  <= frame_cnt_d;
            line_cnt_q   <= line_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            last_lines_q <= last_lines_d;
            last_pix_q   <= last_pix_d;
            size_err_q   <= size_err_d;
            rdata_q      <= rdata_d;
        end
    end

`ifdef VIP_CTRL_IRQ_EN
    logic irq_flag_q, irq_flag_d, irq_en_q, irq_en_d, irq_q, irq_d;

    always_comb begin
        irq_flag_d = (irq_flag_q & ~(wr_status_c & av_writedata[3])) | frame_end_c;
        irq_en_d   = wr_irqen_c ? av_writedata[0] : irq_en_q;
        irq_d      = irq_flag_q & irq_en_q;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            irq_flag_q <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            irq_flag_q <= irq_flag_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
        end
    end

    assign irq_flag_c = irq_flag_q;
    assign irq_en_c   = irq_en_q;
    assign irq        = irq_q;
`else
    assign irq_flag_c = 1'b0;
    assign irq_en_c   = 1'b0;
    assign irq        = 1'b0;
`endif

    assign unused_c = ^{av_writedata[31:8], wr_irqen_c};

    assign {dscale_scale, dscale_en, yuv2rgb_en, sobel_en, hist_equ_en} = active_q;
    assign av_readdata = rdata_q;

endmodule
